fifo_rd_stream_adapter: RTL and testbench
=========================================

FIFO_RD_STREAM_ADAPTER -- requirements
Module: fifo_rd_stream_adapter

Interface
REQ-001 Parameter c_DATA_WIDTH, default 44: FIFO word and stream data width.
REQ-002 Parameter c_LAST_BIT, default 43: rd_data bit index carrying end-of-frame.
REQ-003 Parameter c_CNT_WIDTH, default 16: width of the word and frame counters.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset: rd_clk (input, 1 bit, FIFO read-side clock) and rd_rst_n (input, 1 bit, async active-low reset); all logic SHALL be clocked by rd_clk.
REQ-005 en  input  1  enables new FIFO reads; buffered words still drain when low.
REQ-006 rd_en  output  1  FIFO read request; also acts as the FIFO RAM read clock enable.
REQ-007 rd_data  input  c_DATA_WIDTH  FIFO read data, valid 1 cycle after an accepted rd_en.
REQ-008 rd_empty  input  1  FIFO empty flag.
REQ-009 rd_oce  output  1  FIFO output-register enable, constant 1.
REQ-010 m_data  output  c_DATA_WIDTH  stream data.
REQ-011 m_valid  output  1  stream valid.
REQ-012 m_last  output  1  equals m_data[c_LAST_BIT].
REQ-013 m_ready  input  1  stream ready.
REQ-014 word_cnt  output  c_CNT_WIDTH  stream words transferred, wrapping.
REQ-015 frame_cnt  output  c_CNT_WIDTH  stream words with m_last transferred, wrapping.

Function
REQ-016 The FIFO SHALL be used with c_OUTPUT_REG=0; read latency SHALL be exactly 1 cycle: rd_en high with rd_empty low in cycle N means rd_data is captured in cycle N+1.
REQ-017 Captured words SHALL go into a 3-entry in-order prefetch buffer; occ (0..3) counts stored words and infl (0..1) counts the read issued in the previous cycle.
REQ-018 rd_en SHALL be registered-state-only (no combinational path from m_ready): rd_en = en && !rd_empty && (occ + infl) <= 2.
REQ-019 Buffer overflow SHALL be impossible by construction; with m_ready held high and FIFO non-empty, the stream SHALL sustain one word per cycle.
REQ-020 m_valid SHALL equal (occ != 0); m_data SHALL be the oldest buffered word, driven from a register.
REQ-021 Transfer occurs when m_valid && m_ready; the word is popped and word_cnt increments by 1, and frame_cnt also increments if m_last.
REQ-022 Capture and pop in the same cycle SHALL leave occ unchanged and preserve order.
REQ-023 m_data/m_valid SHALL stay stable while m_valid && !m_ready.
REQ-024 Deasserting en SHALL stop new rd_en from the next evaluation; an in-flight read SHALL still be captured.
REQ-025 Counters SHALL wrap from 2^c_CNT_WIDTH-1 to 0.
REQ-026 rd_empty rising in the same cycle as a would-be read SHALL suppress rd_en; the block SHALL never assert rd_en while rd_empty is high.

Reset
REQ-027 On rd_rst_n low, asynchronously: occ=0, infl=0, m_valid=0, m_data=0, m_last=0, word_cnt=0, frame_cnt=0, rd_en=0; rd_oce remains 1.
REQ-028 A reset asserted mid-transfer SHALL discard all buffered and in-flight words; the FIFO read side SHALL be reset together with this block.
REQ-029 Reset release SHALL be synchronized to rd_clk by the instantiating level; the first rd_en is allowed one cycle after release.

Structure
REQ-030 Package fifo_rd_pkg SHALL hold the default widths, c_LAST_BIT, and the buffer depth constant (3).
REQ-031 The 3-entry buffer SHALL be a sub-module named fifo_rd_prefetch_buf (push, pop, data, occ), with issue control and counters in the top.

Verification
REQ-032 Write 8 words (last on word 8), m_ready=1, en=1 -> 8 consecutive m_valid cycles after a 2-cycle startup; word_cnt=8, frame_cnt=1.
REQ-033 FIFO holds 10 words, m_ready=0 -> exactly 3 rd_en pulses, occ=3, no further reads; m_ready=1 -> remaining 7 stream back-to-back, order preserved.
REQ-034 m_ready toggled 1/0 every cycle over 20 words -> no loss or duplication; rd_en never high while rd_empty is high.
REQ-035 en dropped while 1 read is in flight -> that word plus buffered words are delivered, then m_valid=0, rd_en stays 0.
REQ-036 rd_rst_n pulsed low with occ=2 -> all outputs reset in the same cycle; after release, fresh words stream starting at word_cnt=0.
REQ-037 Preload word_cnt near 0xFFFF via 65537 transfers -> wraps to 1.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared constants and types for the FIFO read-side stream adapter.
package fifo_rd_pkg;

  localparam int unsigned DefDataWidth = 44;
  localparam int unsigned DefLastBit   = 43;
  localparam int unsigned DefCntWidth  = 16;

  // Prefetch buffer depth and the width of its occupancy count (0..3).
  localparam int unsigned BufDepth = 3;
  localparam int unsigned OccWidth = 2;

  typedef logic [OccWidth-1:0] occ_t;

endpackage

// File: rtl/fifo_rd_prefetch_buf.sv
// In-order prefetch buffer: entry 0 is always the oldest word and is
// presented directly from its register. A pop shifts the entries down and a
// push lands at the first free slot after any pop in the same cycle.
module fifo_rd_prefetch_buf
  import fifo_rd_pkg::*;
#(
  parameter int unsigned c_DATA_WIDTH = DefDataWidth
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [c_DATA_WIDTH-1:0] wr_data,
  input  logic                    pop,
  output logic [c_DATA_WIDTH-1:0] data,
  output occ_t                    occ
);

  logic [c_DATA_WIDTH-1:0] mem_q [BufDepth];
  logic [c_DATA_WIDTH-1:0] mem_d [BufDepth];
  occ_t                    occ_q, occ_d, wr_idx;

  // Next-state: shift on pop, then write at the post-pop tail.
  always_comb begin
    mem_d  = mem_q;
    wr_idx = occ_q - occ_t'(pop);
    if (pop) begin
      for (int unsigned i = 0; i < BufDepth - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
      mem_d[BufDepth-1] = '0;
    end
    if (push) begin
      mem_d[wr_idx] = wr_data;
    end
    occ_d = occ_q + occ_t'(push) - occ_t'(pop);
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      occ_q <= '0;
    end else begin
      mem_q <= mem_d;
      occ_q <= occ_d;
    end
  end

  assign data = mem_q[0];
  assign occ  = occ_q;

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Adapts a 1-cycle-latency FIFO read port to a valid/ready stream. Reads are
// issued only while the prefetch buffer plus the in-flight read leave room,
// so the buffer can never overflow and m_ready has no path to rd_en.
module fifo_rd_stream_adapter
  import fifo_rd_pkg::*;
#(
  parameter int unsigned c_DATA_WIDTH = DefDataWidth,
  parameter int unsigned c_LAST_BIT   = DefLastBit,
  parameter int unsigned c_CNT_WIDTH  = DefCntWidth
) (
  input  logic                    rd_clk,
  input  logic                    rd_rst_n,
  input  logic                    en,
  output logic                    rd_en,
  input  logic [c_DATA_WIDTH-1:0] rd_data,
  input  logic                    rd_empty,
  output logic                    rd_oce,
  output logic [c_DATA_WIDTH-1:0] m_data,
  output logic                    m_valid,
  output logic                    m_last,
  input  logic                    m_ready,
  output logic [c_CNT_WIDTH-1:0]  word_cnt,
  output logic [c_CNT_WIDTH-1:0]  frame_cnt
);

  logic                   infl_q;
  occ_t                   occ;
  logic                   xfer;
  logic [c_CNT_WIDTH-1:0] word_cnt_q, frame_cnt_q;

  assign rd_oce = 1'b1;

  // Issue depends only on registered occupancy; reset forces it low at once.
  assign rd_en = rd_rst_n & en & ~rd_empty &
                 ((3'(occ) + 3'(infl_q)) <= 3'(BufDepth - 1));

  assign m_valid = (occ != '0);
  assign m_last  = m_data[c_LAST_BIT];
  assign xfer    = m_valid & m_ready;

  fifo_rd_prefetch_buf #(
    .c_DATA_WIDTH(c_DATA_WIDTH)
  ) u_buf (
    .clk    (rd_clk),
    .rst_n  (rd_rst_n),
    .push   (infl_q),
    .wr_data(rd_data),
    .pop    (xfer),
    .data   (m_data),
    .occ    (occ)
  );

  // Track the read issued last cycle; its data is captured this cycle.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      infl_q <= 1'b0;
    end else begin
      infl_q <= rd_en;
    end
  end

  // Wrapping transfer and end-of-frame counters.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      word_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else if (xfer) begin
      word_cnt_q <= word_cnt_q + 1'b1;
      if (m_last) begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

  assign word_cnt  = word_cnt_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: behavioural 1-cycle-latency FIFO, a
// scoreboard queue filled on FIFO writes and drained on stream transfers,
// a table of streaming scenarios and hand-written corner sequences.
module tb_fifo_rd_stream_adapter;

  localparam int DW = 44;
  localparam int LB = 43;
  localparam int CW = 16;
  localparam int FD = 256;

  logic          rd_clk   = 1'b0;
  logic          rd_rst_n = 1'b1;
  logic          en       = 1'b0;
  logic          m_ready  = 1'b0;
  logic          rd_en, rd_empty, rd_oce, m_valid, m_last;
  logic [DW-1:0] rd_data, m_data;
  logic [CW-1:0] word_cnt, frame_cnt;

  fifo_rd_stream_adapter dut (
    .rd_clk   (rd_clk),
    .rd_rst_n (rd_rst_n),
    .en       (en),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_empty (rd_empty),
    .rd_oce   (rd_oce),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_last   (m_last),
    .m_ready  (m_ready),
    .word_cnt (word_cnt),
    .frame_cnt(frame_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  // FIFO model
  logic [DW-1:0] fifo_mem [FD];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  assign rd_empty = (wr_ptr == rd_ptr);

  always @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      rd_ptr  <= wr_ptr;
      rd_data <= '0;
    end else if (rd_en && !rd_empty) begin
      rd_data <= fifo_mem[rd_ptr % FD];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  // Scoreboard and counters
  logic [DW-1:0] exp_q [$];
  int            n_chk     = 0;
  int            n_pass    = 0;
  int            xfers     = 0;
  int            rd_pulses = 0;
  int            seq       = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endfunction

  function automatic void check_xfer();
    logic [DW-1:0] e;
    chk("xfer_expected", 64'(exp_q.size() != 0), 64'(1));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("xfer_data", 64'(m_data), 64'(e));
      chk("xfer_last", 64'(m_last), 64'(e[LB]));
    end
  endfunction

  // Monitor, sampled on the falling edge
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  always @(negedge rd_clk) begin
    if (!rd_rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (rd_empty) chk("rd_en_while_empty", 64'(rd_en), 64'(0));
      if (rd_en) rd_pulses <= rd_pulses + 1;
      if (prev_stall) begin
        chk("stall_valid", 64'(m_valid), 64'(1));
        chk("stall_data", 64'(m_data), 64'(prev_data));
      end
      if (m_valid && m_ready) begin
        check_xfer();
        xfers <= xfers + 1;
      end
      prev_stall <= m_valid && !m_ready;
      prev_data  <= m_data;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge rd_clk);
      #1;
    end
  endtask

  function automatic logic [DW-1:0] make_word(input logic last);
    seq++;
    return {last, 43'(seq * 32'h9E37_79B1) ^ 43'(seq)};
  endfunction

  task automatic put_word(input logic last);
    logic [DW-1:0] w;
    w = make_word(last);
    fifo_mem[wr_ptr % FD] = w;
    exp_q.push_back(w);
    wr_ptr++;
  endtask

  task automatic rst_pulse();
    rd_rst_n = 1'b0;
    en       = 1'b0;
    m_ready  = 1'b0;
    step(2);
    exp_q.delete();
    rd_rst_n = 1'b1;
    step(1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, 64'(rd_en), 64'(0));
    chk({tag, "_rd_oce"}, 64'(rd_oce), 64'(1));
    chk({tag, "_m_valid"}, 64'(m_valid), 64'(0));
    chk({tag, "_m_data"}, 64'(m_data), 64'(0));
    chk({tag, "_m_last"}, 64'(m_last), 64'(0));
    chk({tag, "_word_cnt"}, 64'(word_cnt), 64'(0));
    chk({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(0));
  endtask

  typedef struct {
    int n;
    int last_every;
    int mode;        // 0: ready high, 1: ready toggles, 2: ready random
    int exp_words;
    int exp_frames;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int base, x0, written, guard;

    vecs[0] = '{8, 8, 0, 8, 1};
    vecs[1] = '{20, 5, 1, 20, 4};
    vecs[2] = '{13, 3, 2, 13, 4};
    vecs[3] = '{1, 1, 0, 1, 1};

    // Reset state, with a non-empty FIFO and en high
    #1;
    rd_rst_n = 1'b0;
    put_word(1'b0);
    en = 1'b1;
    #2;
    chk_reset_outputs("por");
    step(2);
    exp_q.delete();
    en       = 1'b0;
    rd_rst_n = 1'b1;
    step(1);

    // Table-driven streaming scenarios
    for (int r = 0; r < 4; r++) begin
      int cyc, first_v;
      rst_pulse();
      for (int i = 1; i <= vecs[r].n; i++) put_word(i % vecs[r].last_every == 0);
      en      = 1'b1;
      cyc     = 0;
      first_v = -1;
      while (exp_q.size() != 0 && cyc < 200) begin
        case (vecs[r].mode)
          0:       m_ready = 1'b1;
          1:       m_ready = (cyc % 2 == 0);
          default: m_ready = 1'($urandom_range(0, 1));
        endcase
        @(negedge rd_clk);
        if (m_valid && first_v < 0) first_v = cyc;
        @(posedge rd_clk);
        #1;
        cyc++;
      end
      step(2);
      chk($sformatf("row%0d_first_valid", r), 64'(first_v), 64'(2));
      chk($sformatf("row%0d_drained", r), 64'(exp_q.size()), 64'(0));
      chk($sformatf("row%0d_idle", r), 64'(m_valid), 64'(0));
      chk($sformatf("row%0d_word_cnt", r), 64'(word_cnt), 64'(vecs[r].exp_words));
      chk($sformatf("row%0d_frame_cnt", r), 64'(frame_cnt), 64'(vecs[r].exp_frames));
      en      = 1'b0;
      m_ready = 1'b0;
    end

    // 10 words, ready low: three reads fill the buffer, then back-to-back
    rst_pulse();
    for (int i = 1; i <= 10; i++) put_word(i == 10);
    base = rd_pulses;
    x0   = xfers;
    en   = 1'b1;
    step(12);
    chk("fill_rd_pulses", 64'(rd_pulses - base), 64'(3));
    chk("fill_valid", 64'(m_valid), 64'(1));
    chk("fill_no_xfer", 64'(xfers - x0), 64'(0));
    m_ready = 1'b1;
    step(10);
    chk("burst_xfers", 64'(xfers - x0), 64'(10));
    chk("burst_idle", 64'(m_valid), 64'(0));
    chk("burst_frame_cnt", 64'(frame_cnt), 64'(1));

    // en dropped with one read in flight
    rst_pulse();
    for (int i = 1; i <= 5; i++) put_word(1'b0);
    base = rd_pulses;
    x0   = xfers;
    en   = 1'b1;
    step(2);
    en = 1'b0;
    step(6);
    chk("endrop_rd_pulses", 64'(rd_pulses - base), 64'(2));
    chk("endrop_valid", 64'(m_valid), 64'(1));
    m_ready = 1'b1;
    step(6);
    chk("endrop_xfers", 64'(xfers - x0), 64'(2));
    chk("endrop_idle", 64'(m_valid), 64'(0));
    chk("endrop_no_more_reads", 64'(rd_pulses - base), 64'(2));
    chk("endrop_left_in_fifo", 64'(exp_q.size()), 64'(3));

    // Mid-cycle reset with two words buffered
    rst_pulse();
    for (int i = 1; i <= 4; i++) put_word(1'b1);
    en = 1'b1;
    step(2);
    en = 1'b0;
    step(3);
    en = 1'b1;
    #1;
    chk("prerst_rd_en", 64'(rd_en), 64'(1));
    chk("prerst_valid", 64'(m_valid), 64'(1));
    #1;
    rd_rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    step(2);
    exp_q.delete();
    en       = 1'b0;
    rd_rst_n = 1'b1;
    step(1);
    x0 = xfers;
    put_word(1'b0);
    put_word(1'b0);
    put_word(1'b1);
    en      = 1'b1;
    m_ready = 1'b1;
    step(8);
    chk("postrst_xfers", 64'(xfers - x0), 64'(3));
    chk("postrst_word_cnt", 64'(word_cnt), 64'(3));
    chk("postrst_frame_cnt", 64'(frame_cnt), 64'(1));
    chk("postrst_drained", 64'(exp_q.size()), 64'(0));

    // Counter wrap: 65537 transfers, every word ends a frame
    rst_pulse();
    en      = 1'b1;
    m_ready = 1'b1;
    x0      = xfers;
    written = 0;
    guard   = 0;
    while ((xfers - x0) < 65537 && guard < 70000) begin
      if (written < 65537 && (wr_ptr - rd_ptr) < 8) begin
        put_word(1'b1);
        written++;
      end
      step(1);
      guard++;
    end
    step(2);
    chk("wrap_xfers", 64'(xfers - x0), 64'(65537));
    chk("wrap_word_cnt", 64'(word_cnt), 64'(1));
    chk("wrap_frame_cnt", 64'(frame_cnt), 64'(1));
    chk("wrap_drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
